// File: rtl/mult_req_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_req_pkg
// Description : Shared types and defaults for the multiply requester.
//               Holds the FSM state encoding and the default DATA_W and
//               TIMEOUT values.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_req_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2,
    RESP = 2'd3
  } req_state_t;

  localparam int DEFAULT_DATA_W  = 8;
  localparam int DEFAULT_TIMEOUT = 15;

endpackage : mult_req_pkg
`default_nettype wire

// File: rtl/mult_req_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : mult_req_watchdog
// Description : Cycle counter with synchronous clear and count enable.
//               expire_o is raised once the count reaches TIMEOUT-1. The
//               counter then holds until it is cleared again.
// Ports       : clk      - clock
//               rst_n    - asynchronous active-low reset
//               clr_i    - clear the count to zero (takes priority)
//               en_i     - count one cycle
//               expire_o - count has reached TIMEOUT-1
// Revision    : 1.0 - initial release
// ============================================================================
module mult_req_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             w_expire;

  assign w_expire = (cnt_q == C_LAST);
  assign expire_o = w_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !w_expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule : mult_req_watchdog
`default_nettype wire

// File: rtl/mult_requester.sv
`default_nettype none
// ============================================================================
// Module      : mult_requester
// Description : Initiator side of a start/done multiply handshake. Accepts
//               one operand command at a time, raises mul_start with the
//               operands held stable until mul_done (or a watchdog timeout).
//               It then forces one cycle of mul_start low and returns the
//               product on a valid/ready response channel.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               cmd_valid/cmd_ready/cmd_a/b - command channel
//               rsp_valid/rsp_ready         - response channel
//               rsp_result/rsp_error        - product (0 on timeout), error
//               mul_start/mul_a/mul_b       - drive to the multiplier
//               mul_done/mul_result         - completion from the multiplier
//               stat_ok/stat_timeout        - response counters (optional)
// Options     : MULT_REQ_STATS_EN - when defined, adds the saturating 16-bit
//               stat_ok / stat_timeout counters and their output ports.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_requester
  import mult_req_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_result,
  output logic                rsp_error,
  output logic                mul_start,
  output logic [DATA_W-1:0]   mul_a,
  output logic [DATA_W-1:0]   mul_b,
  input  logic                mul_done,
  input  logic [2*DATA_W-1:0] mul_result
`ifdef MULT_REQ_STATS_EN
  ,
  output logic [15:0]         stat_ok,
  output logic [15:0]         stat_timeout
`endif
);

  if (TIMEOUT < 8) begin : g_bad_timeout
    $error("mult_requester: TIMEOUT must be >= 8");
  end

  req_state_t state_q, state_d;

  logic                mul_start_q, mul_start_d;
  logic [DATA_W-1:0]   mul_a_q, mul_a_d;
  logic [DATA_W-1:0]   mul_b_q, mul_b_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [2*DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic                rsp_error_q, rsp_error_d;

  logic w_cmd_fire;
  logic w_rsp_fire;
  logic w_wd_expire;

  assign cmd_ready  = (state_q == IDLE);
  assign w_cmd_fire = cmd_valid && (state_q == IDLE);
  assign w_rsp_fire = rsp_valid_q && rsp_ready;

  // Counter is zeroed on command acceptance and runs only while in WAIT.
  mult_req_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (w_cmd_fire),
    .en_i     (state_q == WAIT),
    .expire_o (w_wd_expire)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (w_cmd_fire) state_d = WAIT;
      WAIT: if (mul_done || w_wd_expire) state_d = GAP;
      GAP:  state_d = RESP;
      RESP: if (w_rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values; every output except cmd_ready is registered below.
  always_comb begin
    mul_start_d  = mul_start_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_error_d  = rsp_error_q;
    unique case (state_q)
      IDLE: begin
        if (w_cmd_fire) begin
          mul_a_d     = cmd_a;
          mul_b_d     = cmd_b;
          mul_start_d = 1'b1;
        end
      end
      WAIT: begin
        // A completion arriving on the timeout cycle still counts as good.
        if (mul_done) begin
          rsp_result_d = mul_result;
          rsp_error_d  = 1'b0;
          mul_start_d  = 1'b0;
        end else if (w_wd_expire) begin
          rsp_result_d = '0;
          rsp_error_d  = 1'b1;
          mul_start_d  = 1'b0;
        end
      end
      GAP: begin
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        if (w_rsp_fire) rsp_valid_d = 1'b0;
      end
      default: begin
        mul_start_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_start_q  <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      mul_start_q  <= mul_start_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_error_q  <= rsp_error_d;
    end
  end

  assign mul_start  = mul_start_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_error  = rsp_error_q;

`ifdef MULT_REQ_STATS_EN
  logic [15:0] stat_ok_q;
  logic [15:0] stat_timeout_q;

  // Counted on the response handshake, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ok_q      <= '0;
      stat_timeout_q <= '0;
    end else if (w_rsp_fire) begin
      if (!rsp_error_q && (stat_ok_q != 16'hFFFF)) begin
        stat_ok_q <= stat_ok_q + 16'd1;
      end
      if (rsp_error_q && (stat_timeout_q != 16'hFFFF)) begin
        stat_timeout_q <= stat_timeout_q + 16'd1;
      end
    end
  end

  assign stat_ok      = stat_ok_q;
  assign stat_timeout = stat_timeout_q;
`endif

endmodule : mult_requester
`default_nettype wire
